// File: rtl/mdc_cfg_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mdc_cfg_pkg
// Brief    : State encoding and select-table lookup shared by mdc_reconfig_ctrl.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package mdc_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } cfg_state_e;

    localparam logic [1:0] c_st_idle   = ST_IDLE;
    localparam logic [1:0] c_st_drain  = ST_DRAIN;
    localparam logic [1:0] c_st_switch = ST_SWITCH;
    localparam logic [1:0] c_st_settle = ST_SETTLE;

    // Upper bounds for the width-agnostic table lookup below.
    localparam int c_sel_w_max = 32;
    localparam int c_tbl_max   = 1024;

    // Entry for configuration `id` (1-based); id 0 yields all zeros.
    function automatic logic [c_sel_w_max-1:0] sel_lookup(
        input logic [c_tbl_max-1:0] tbl,
        input int                   sel_w,
        input int                   id
    );
        logic [c_tbl_max-1:0]   w_sh;
        logic [c_sel_w_max-1:0] w_out;
        w_out = '0;
        w_sh  = (id == 0) ? '0 : (tbl >> ((id - 1) * sel_w));
        for (int b = 0; b < c_sel_w_max; b++) begin
            if (b < sel_w) w_out[b] = w_sh[b];
        end
        return w_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdc_reconfig_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mdc_reconfig_ctrl_if
// Brief    : Host request / datapath control bundle; cfg_count exists only
//            when MDC_CFG_CNT_EN is defined.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface mdc_reconfig_ctrl_if #(
    parameter int ID_W  = 8,
    parameter int SEL_W = 2
);
    logic [ID_W-1:0]  id_in;
    logic             id_valid;
    logic             id_ready;
    logic             busy_in;
    logic             hold;
    logic [SEL_W-1:0] sel;
    logic [ID_W-1:0]  cur_id;
    logic             cfg_done;
    logic             cfg_error;
`ifdef MDC_CFG_CNT_EN
    logic [15:0]      cfg_count;

    modport master (
        output id_in, id_valid, busy_in,
        input  id_ready, hold, sel, cur_id, cfg_done, cfg_error, cfg_count
    );
    modport slave (
        input  id_in, id_valid, busy_in,
        output id_ready, hold, sel, cur_id, cfg_done, cfg_error, cfg_count
    );
`else
    modport master (
        output id_in, id_valid, busy_in,
        input  id_ready, hold, sel, cur_id, cfg_done, cfg_error
    );
    modport slave (
        input  id_in, id_valid, busy_in,
        output id_ready, hold, sel, cur_id, cfg_done, cfg_error
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mdc_cfg_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mdc_cfg_timer
// Brief    : Loadable down-counter that stops at zero and flags it.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mdc_cfg_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_en,
    output logic                  o_zero
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/mdc_reconfig_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mdc_reconfig_ctrl
// Brief    : Sequential drain/switch/settle configurator for merged dataflow
//            switch boxes. Optional MDC_CFG_CNT_EN adds a saturating cfg_count.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mdc_reconfig_ctrl
    import mdc_cfg_pkg::*;
#(
    parameter int                     ID_W       = 8,
    parameter int                     SEL_W      = 2,
    parameter int                     N_CFG      = 2,
    parameter logic [N_CFG*SEL_W-1:0] SEL_TABLE  = {2'b11, 2'b00},
    parameter int                     SETTLE_CYC = 2,
    parameter int                     DRAIN_MAX  = 255
) (
    input  wire logic          clock,
    input  wire logic          reset,
    mdc_reconfig_ctrl_if.slave bus
);
    localparam int c_drn_w = $clog2(DRAIN_MAX + 1);
    localparam int c_stl_w = $clog2(SETTLE_CYC + 1);
    localparam logic [c_drn_w-1:0]   c_drn_load = c_drn_w'(DRAIN_MAX - 1);
    localparam logic [c_stl_w-1:0]   c_stl_load = c_stl_w'(SETTLE_CYC - 1);
    localparam logic [c_tbl_max-1:0] c_table    = c_tbl_max'(SEL_TABLE);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_cur_id;
    logic [SEL_W-1:0] r_sel;
    logic             r_done;
    logic             r_error;

    logic                   w_accept;
    logic                   w_legal;
    logic                   w_start;
    logic                   w_drn_zero;
    logic                   w_stl_zero;
    logic                   w_settle_end;
    logic [c_sel_w_max-1:0] w_lookup;

    assign w_accept     = bus.id_valid && bus.id_ready;
    assign w_legal      = (bus.id_in != '0) && (32'(bus.id_in) <= 32'(N_CFG));
    assign w_start      = w_accept && w_legal && (bus.id_in != r_cur_id);
    assign w_settle_end = (r_state == c_st_settle) && w_stl_zero;
    assign w_lookup     = sel_lookup(c_table, SEL_W, int'(r_id));

    generate
        if (SEL_W < c_sel_w_max) begin : g_sel_unused
            logic w_sel_unused;
            assign w_sel_unused = ^w_lookup[c_sel_w_max-1:SEL_W];
        end
    endgenerate

    mdc_cfg_timer #(.WIDTH(c_drn_w)) u_drain_tmr (
        .clk        (clock),
        .rst        (reset),
        .i_load     (w_start),
        .i_load_val (c_drn_load),
        .i_en       (r_state == c_st_drain),
        .o_zero     (w_drn_zero)
    );

    mdc_cfg_timer #(.WIDTH(c_stl_w)) u_settle_tmr (
        .clk        (clock),
        .rst        (reset),
        .i_load     (r_state == c_st_switch),
        .i_load_val (c_stl_load),
        .i_en       (r_state == c_st_settle),
        .o_zero     (w_stl_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_id     <= '0;
            r_cur_id <= '0;
            r_sel    <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_error <= 1'b1;
                        end else if (bus.id_in == r_cur_id) begin
                            r_done <= 1'b1;
                        end else begin
                            r_id    <= bus.id_in;
                            r_state <= c_st_drain;
                        end
                    end
                end
                // An idle fabric wins over a simultaneous timeout.
                c_st_drain: begin
                    if (!bus.busy_in) begin
                        r_state <= c_st_switch;
                    end else if (w_drn_zero) begin
                        r_error <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                c_st_switch: begin
                    r_sel    <= w_lookup[SEL_W-1:0];
                    r_cur_id <= r_id;
                    r_state  <= c_st_settle;
                end
                c_st_settle: begin
                    if (w_stl_zero) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef MDC_CFG_CNT_EN
    logic [15:0] r_cfg_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg_count <= '0;
        end else if (w_settle_end && (r_cfg_count != 16'hFFFF)) begin
            r_cfg_count <= r_cfg_count + 16'd1;
        end
    end

    assign bus.cfg_count = r_cfg_count;
`else
    logic w_settle_end_unused;
    assign w_settle_end_unused = w_settle_end;
`endif

    assign bus.id_ready  = (r_state == c_st_idle) && !reset;
    assign bus.hold      = (r_state != c_st_idle);
    assign bus.sel       = r_sel;
    assign bus.cur_id    = r_cur_id;
    assign bus.cfg_done  = r_done;
    assign bus.cfg_error = r_error;
endmodule
`default_nettype wire

// File: tb/tb_mdc_reconfig_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mdc_reconfig_ctrl
// Brief    : Randomised scoreboard bench for mdc_reconfig_ctrl (MDC_CFG_CNT_EN
//            optional).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_mdc_reconfig_ctrl;
    localparam int ID_W       = 8;
    localparam int SEL_W      = 2;
    localparam int N_CFG      = 2;
    localparam int SETTLE_CYC = 2;
    localparam int DRAIN_MAX  = 12;
    localparam int N_TXN      = 80;
    localparam int N_DIR      = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mdc_reconfig_ctrl_if #(.ID_W(ID_W), .SEL_W(SEL_W)) bus ();

    mdc_reconfig_ctrl #(
        .ID_W       (ID_W),
        .SEL_W      (SEL_W),
        .N_CFG      (N_CFG),
        .SEL_TABLE  ({2'b11, 2'b00}),
        .SETTLE_CYC (SETTLE_CYC),
        .DRAIN_MAX  (DRAIN_MAX)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        bit err;
    } pulse_t;

    // Select vector per configuration, written out directly from the table.
    logic [SEL_W-1:0] ref_tab [1:N_CFG] = '{2'b00, 2'b11};

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    bit  in_reset = 1'b1;
    pulse_t pq[$];

    // Expected-waveform description, refreshed at every accepted request.
    int               h_lo = 0, h_hi = 0, s_cyc = 0, cnt_cyc = 0;
    int               b_lo = 0, b_hi = 0, idle_at = 0;
    logic [SEL_W-1:0] s_old = '0, s_new = '0;
    logic [ID_W-1:0]  c_old = '0, c_new = '0;
    int               cnt_old = 0, cnt_new = 0;
    logic [SEL_W-1:0] m_sel = '0;
    int               m_cur = 0, m_cnt = 0;

    int dir_id [N_DIR] = '{2, 2, 0, 3, 1, 2, 2, 255};
    int dir_b  [N_DIR] = '{0, 0, 0, 0, 10, 12, 11, 0};
    int dir_g  [N_DIR] = '{0, 0, 1, 0, 2, 0, 0, 1};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    task automatic model_accept(input int a, input int id, input int b);
        pulse_t p;
        s_old = m_sel;  s_new = m_sel;
        c_old = ID_W'(m_cur); c_new = ID_W'(m_cur);
        cnt_old = m_cnt; cnt_new = m_cnt;
        if (id < 1 || id > N_CFG) begin
            p = '{a + 1, 1'b1};
            idle_at = a + 1;
        end else if (id == m_cur) begin
            p = '{a + 1, 1'b0};
            idle_at = a + 1;
        end else if (b < DRAIN_MAX) begin
            // b busy DRAIN cycles, one switch cycle, then SETTLE_CYC settle cycles
            p = '{a + 3 + b + SETTLE_CYC, 1'b0};
            s_cyc = a + 3 + b;
            s_new = ref_tab[id];
            c_new = ID_W'(id);
            h_lo = a + 1;  h_hi = p.cyc;  idle_at = p.cyc;
            m_sel = s_new; m_cur = id;
            if (m_cnt < 65535) m_cnt++;
            cnt_new = m_cnt; cnt_cyc = p.cyc;
        end else begin
            p = '{a + 1 + DRAIN_MAX, 1'b1};
            h_lo = a + 1;  h_hi = p.cyc;  idle_at = p.cyc;
        end
        b_lo = a + 1;
        b_hi = a + 1 + b;
        pq.push_back(p);
    endtask

    task automatic pick(input int k, output int id, output int b, output int gap);
        if (k < N_DIR) begin
            id = dir_id[k]; b = dir_b[k]; gap = dir_g[k];
        end else begin
            case ($urandom_range(0, 9))
                0:       id = 0;
                1:       id = int'($urandom_range(N_CFG + 1, 255));
                default: id = int'($urandom_range(1, N_CFG));
            endcase
            b   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, DRAIN_MAX + 2));
            gap = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
        end
    endtask

    // Monitor: per-cycle waveform checks and scoreboard pops on pulses.
    always @(negedge clock) begin
        pulse_t p;
        if (!in_reset) begin
            chk("hold", 32'(bus.hold), 32'(cyc >= h_lo && cyc < h_hi));
            chk("id_ready", 32'(bus.id_ready), 32'(!(cyc >= h_lo && cyc < h_hi)));
            chk("sel", 32'(bus.sel), 32'((cyc >= s_cyc) ? s_new : s_old));
            chk("cur_id", 32'(bus.cur_id), 32'((cyc >= s_cyc) ? c_new : c_old));
`ifdef MDC_CFG_CNT_EN
            chk("cfg_count", 32'(bus.cfg_count), 32'((cyc >= cnt_cyc) ? cnt_new : cnt_old));
`endif
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                p = pq.pop_front();
                chk("cfg_done", 32'(bus.cfg_done), 32'(!p.err));
                chk("cfg_error", 32'(bus.cfg_error), 32'(p.err));
            end else begin
                chk("no_pulse", 32'({bus.cfg_done, bus.cfg_error}), 32'd0);
            end
        end
    end

    initial begin
        int req_id, req_b, req_gap, raise, k, a, nid;
        bus.id_in    = '0;
        bus.id_valid = 1'b0;
        bus.busy_in  = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_cur_id", 32'(bus.cur_id), 32'd0);
        chk("rst_hold", 32'(bus.hold), 32'd0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'd0);
        chk("rst_pulses", 32'({bus.cfg_done, bus.cfg_error}), 32'd0);
`ifdef MDC_CFG_CNT_EN
        chk("rst_cfg_count", 32'(bus.cfg_count), 32'd0);
`endif
        reset    = 1'b0;
        in_reset = 1'b0;
        idle_at  = cyc;
        k        = 0;
        pick(k, req_id, req_b, req_gap);
        raise = cyc + 1;

        while (k < N_TXN) begin
            @(posedge clock);
            #2;
            if (cyc >= b_lo && cyc < b_hi)  bus.busy_in = 1'b1;
            else if (cyc >= idle_at)        bus.busy_in = 1'($urandom_range(0, 1));
            else                            bus.busy_in = 1'b0;
            if (cyc >= raise) begin
                bus.id_valid = 1'b1;
                bus.id_in    = ID_W'(req_id);
                if (cyc >= idle_at) begin
                    model_accept(cyc, req_id, req_b);
                    k++;
                    pick(k, req_id, req_b, req_gap);
                    raise = cyc + 1 + req_gap;
                end
            end else begin
                bus.id_valid = 1'b0;
                bus.id_in    = ID_W'($urandom);
            end
        end

        while (cyc < idle_at + 2) begin
            @(posedge clock);
            #2;
            bus.id_valid = 1'b0;
            bus.busy_in  = 1'b0;
        end

        // Switch, then pull reset during the first SETTLE cycle.
        nid = (m_cur == 1) ? 2 : 1;
        @(posedge clock);
        #2;
        a = cyc;
        bus.id_valid = 1'b1;
        bus.id_in    = ID_W'(nid);
        model_accept(a, nid, 0);
        @(posedge clock);
        #2;
        bus.id_valid = 1'b0;
        while (cyc < a + 3) begin
            @(posedge clock);
            #2;
        end
        reset    = 1'b1;
        in_reset = 1'b1;
        pq.delete();
        @(posedge clock);
        #2;
        chk("mid_rst_sel", 32'(bus.sel), 32'd0);
        chk("mid_rst_cur_id", 32'(bus.cur_id), 32'd0);
        chk("mid_rst_hold", 32'(bus.hold), 32'd0);
        chk("mid_rst_id_ready", 32'(bus.id_ready), 32'd0);
        chk("mid_rst_pulses", 32'({bus.cfg_done, bus.cfg_error}), 32'd0);
`ifdef MDC_CFG_CNT_EN
        chk("mid_rst_cfg_count", 32'(bus.cfg_count), 32'd0);
`endif
        reset = 1'b0;
        m_sel = '0; m_cur = 0; m_cnt = 0;
        h_lo = 0; h_hi = 0; s_cyc = 0; cnt_cyc = 0;
        s_old = '0; s_new = '0; c_old = '0; c_new = '0;
        cnt_old = 0; cnt_new = 0;
        in_reset = 1'b0;

        // Controller must be fully usable again after the abort.
        repeat (4) @(posedge clock);
        #2;
        bus.id_valid = 1'b1;
        bus.id_in    = ID_W'(2);
        model_accept(cyc, 2, 0);
        @(posedge clock);
        #2;
        bus.id_valid = 1'b0;
        while (cyc < idle_at + 3) begin
            @(posedge clock);
            #2;
        end
        if (pq.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain pending=%0d required=0", pq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
